// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory Wishbone master
package dmem_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} mem_size_e;
  typedef logic [1:0] state_e;
  localparam state_e IDLE = 2'd0;
  localparam state_e BUS  = 2'd1;
  localparam state_e RESP = 2'd2;
  function automatic int unsigned size_bytes(mem_size_e s);
    return 32'd1 << s;
  endfunction
  function automatic logic is_aligned(logic [2:0] a, mem_size_e s);
    return (a & ((3'd1 << s) - 3'd1)) == 3'd0;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and lane extraction/extension for loads
module dmem_lane_align import dmem_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int LSB = $clog2(NB)
) (
  input  logic [LSB-1:0]        lane,
  input  mem_size_e             size,
  input  logic                  uns,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [NB-1:0]         sel,
  output logic [DATA_WIDTH-1:0] wdata_lane,
  output logic [DATA_WIDTH-1:0] rdata_ext
);
  logic [NB-1:0] m;
  logic [DATA_WIDTH-1:0] wm, rs;
  logic sgn;
  always_comb begin
    m = '0;
    wm = '0;
    sgn = 1'b0;
    rdata_ext = '0;
    rs = rdata >> {lane, 3'b000};
    for (int i = 0; i < NB; i++) begin
      m[i] = 32'(i) < size_bytes(size);
      wm[8*i+:8] = m[i] ? wdata[8*i+:8] : 8'h00;
      sgn = m[i] ? rs[8*i+7] : sgn;
    end
    for (int i = 0; i < NB; i++)
      rdata_ext[8*i+:8] = m[i] ? rs[8*i+:8] : {8{sgn & ~uns}};
  end
  assign sel = m << lane;
  assign wdata_lane = wm << {lane, 3'b000};
endmodule

// File: rtl/dmem_wb_master.sv
// dmem_wb_master: single-outstanding data-memory Wishbone B4 classic master for the MEM stage
module dmem_wb_master import dmem_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int NB = DATA_WIDTH / 8,
  localparam int LSB = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  mem_err_o,
  output logic                  stall_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [NB-1:0]         wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_e state;
  mem_size_e size_in, size_q;
  logic [LSB-1:0] lane_q;
  logic uns_q, err_q, ok, tmo, term;
  logic [CW-1:0] cnt;
  logic [NB-1:0] sel_c;
  logic [DATA_WIDTH-1:0] wdat_c, rdat_c, rdata_q;
  assign size_in = mem_size_e'(mem_size_i);
  assign ok = is_aligned(mem_addr_i[2:0], size_in) && (size_in != DWORD || DATA_WIDTH == 64);
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign term = wb_ack_i || wb_err_i || tmo;
  assign stall_o = (state == IDLE && mem_req_i) || state == BUS;
  assign mem_done_o = state == RESP;
  assign mem_err_o = mem_done_o && err_q;
  assign mem_rdata_o = rdata_q;
  // store steering uses the live request in IDLE; load extraction uses the captured lane in BUS
  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .lane(state == BUS ? lane_q : mem_addr_i[LSB-1:0]),
    .size(state == BUS ? size_q : size_in),
    .uns(uns_q),
    .wdata(mem_wdata_i),
    .rdata(wb_dat_i),
    .sel(sel_c),
    .wdata_lane(wdat_c),
    .rdata_ext(rdat_c)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      {wb_cyc_o, wb_stb_o, wb_we_o, uns_q, err_q} <= '0;
      {wb_adr_o, wb_dat_o, wb_sel_o, rdata_q, lane_q, cnt} <= '0;
      size_q <= BYTE;
    end else if (state == IDLE) begin
      if (mem_req_i) begin
        state <= ok ? BUS : RESP;
        {wb_cyc_o, wb_stb_o, wb_we_o} <= {ok, ok, ok && mem_we_i};
        wb_adr_o <= {mem_addr_i[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
        wb_sel_o <= sel_c;
        wb_dat_o <= wdat_c;
        lane_q <= mem_addr_i[LSB-1:0];
        size_q <= size_in;
        uns_q <= mem_unsigned_i;
        err_q <= !ok;
        rdata_q <= '0;
        cnt <= '0;
      end
    end else if (state == BUS) begin
      if (term) begin
        state <= RESP;
        {wb_cyc_o, wb_stb_o, wb_we_o} <= 3'b000;
        err_q <= wb_err_i || !wb_ack_i;
        rdata_q <= (wb_ack_i && !wb_err_i && !wb_we_o) ? rdat_c : '0;
      end else cnt <= cnt + 1'b1;
    end else state <= IDLE;
  end
endmodule

// File: tb/tb_dmem_wb_master.sv
// tb_dmem_wb_master: randomized and directed checks against an arithmetic reference model
module tb_dmem_wb_master;
  localparam int TO = 4;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic mem_req_i = 0, mem_we_i = 0, mem_unsigned_i = 0;
  logic [1:0] mem_size_i = 0;
  logic [31:0] mem_addr_i = 0, mem_wdata_i = 0, mem_rdata_o;
  logic mem_done_o, mem_err_o, stall_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = 0;
  logic [3:0] wb_sel_o;
  logic wb_ack_i = 0, wb_err_i = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk_i = ~clk_i;
  dmem_wb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_err_o(mem_err_o), .stall_o(stall_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // dly: cycles into the bus cycle before the slave answers; berr: answer with err (plus ack if both)
  task automatic access(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly, input bit berr,
                        input bit both);
    int nb = 1 << sz;
    int lane = int'(addr % 4);
    int n = 0;
    bit mis = (addr % nb) != 0 || sz == 2'd3;
    logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
    logic [63:0] v = ({32'd0, rd} >> (8 * lane)) & mask;
    bit exp_err;
    int exp_cyc;
    logic [31:0] exp_rd;
    if (!uns && !mis && v[8*nb-1]) v = v | ~mask;
    exp_err = mis || berr || dly >= TO;
    exp_cyc = mis ? 0 : (dly < TO ? dly + 1 : TO);
    exp_rd = (exp_err || we) ? 32'd0 : v[31:0];
    @(negedge clk_i);
    mem_req_i = 1; mem_we_i = we; mem_size_i = sz; mem_unsigned_i = uns;
    mem_addr_i = addr; mem_wdata_i = wd;
    #1 check("stall_req", stall_o, 1);
    @(negedge clk_i);
    while (wb_cyc_o && n < 20) begin
      check("stb", wb_stb_o, 1);
      check("we", wb_we_o, we);
      check("adr", wb_adr_o, addr & ~32'd3);
      check("sel", wb_sel_o, ((1 << nb) - 1) << lane);
      check("dat", wb_dat_o, (wd & mask[31:0]) << (8 * lane));
      check("stall_bus", stall_o, 1);
      check("done_bus", mem_done_o, 0);
      wb_ack_i = (n == dly) && (!berr || both);
      wb_err_i = (n == dly) && berr;
      wb_dat_i = (n == dly) ? rd : $urandom;
      n++;
      @(negedge clk_i);
    end
    wb_ack_i = 0; wb_err_i = 0;
    check("cyc_len", n, exp_cyc);
    check("cyc_resp", wb_cyc_o, 0);
    check("done", mem_done_o, 1);
    check("err", mem_err_o, exp_err);
    check("rdata", mem_rdata_o, exp_rd);
    check("stall_resp", stall_o, 0);
    mem_req_i = 0;
    @(negedge clk_i);
    check("done_pulse", mem_done_o, 0);
    check("cyc_idle", wb_cyc_o, 0);
  endtask
  initial begin
    #1;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", wb_sel_o, 0);
    check("rst_rdata", mem_rdata_o, 0);
    check("rst_done", mem_done_o, 0);
    check("rst_err", mem_err_o, 0);
    mem_req_i = 1;
    #1 check("rst_stall_req", stall_o, 1);
    mem_req_i = 0;
    #1 check("rst_stall_idle", stall_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    access(0, 2'd0, 0, 32'h1003, 0, 32'h80112233, 0, 0, 0);
    access(0, 2'd1, 1, 32'h2002, 0, 32'hBEEF0000, 0, 0, 0);
    access(1, 2'd1, 0, 32'h3002, 32'hABCD1234, 32'h5555AAAA, 0, 0, 0);
    access(0, 2'd2, 0, 32'h4001, 0, 0, 0, 0, 0);
    access(0, 2'd2, 0, 32'h5000, 0, 32'h1, 9, 0, 0);
    access(0, 2'd2, 0, 32'h5004, 0, 32'hCAFEF00D, 2, 0, 0);
    access(0, 2'd2, 0, 32'h6000, 0, 32'h12345678, 1, 1, 1);
    access(1, 2'd3, 0, 32'h6008, 32'h1, 0, 0, 0, 0);
    access(0, 2'd1, 0, 32'h7006, 0, 32'h8001FFFF, 3, 0, 0);
    @(negedge clk_i);
    mem_req_i = 1; mem_we_i = 0; mem_size_i = 2'd2; mem_addr_i = 32'h7000;
    @(negedge clk_i);
    check("cyc_open", wb_cyc_o, 1);
    #2 rst_i = 1;
    #1 check("cyc_async_rst", wb_cyc_o, 0);
    check("stb_async_rst", wb_stb_o, 0);
    mem_req_i = 0;
    repeat (2) begin
      @(negedge clk_i);
      check("done_rst", mem_done_o, 0);
    end
    rst_i = 0;
    access(0, 2'd2, 1, 32'h7004, 0, 32'hFEEDBEEF, 0, 0, 0);
    for (int k = 0; k < 200; k++) begin
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 5), $urandom_range(0, 7) == 0, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_wb_master.md
# dmem_wb_master

Parametrised data-memory Wishbone master between the CPU MEM stage and the Wishbone bus; successor to the byte/word data-memory port. Adds byte/half/word/dword sizes, signed and unsigned loads, misalignment detection, bus-error and timeout reporting, and a one-cycle completion pulse. It runs one transaction at a time and stalls the pipeline while a bus cycle is open.

## Interface
- DATA_WIDTH, 32: bus and CPU data width; 32 or 64.
- ADDR_WIDTH, 32: byte address width.
- TIMEOUT_CYCLES, 256: maximum cycles a bus cycle may stay open before it is aborted; 0 disables the timeout.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mem_req_i  in  1  access request; held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_WIDTH=64).
- mem_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- mem_addr_i  in  ADDR_WIDTH  byte address.
- mem_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- mem_rdata_o  out  DATA_WIDTH  extended load data; valid while mem_done_o=1.
- mem_done_o  out  1  one-cycle completion pulse.
- mem_err_o  out  1  qualifies mem_done_o: misaligned, wb_err_i, or timeout.
- stall_o  out  1  pipeline stall.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone B4 classic controls.
- wb_adr_o  out  ADDR_WIDTH  address, with the low log2(DATA_WIDTH/8) bits forced to 0.
- wb_dat_o  out  DATA_WIDTH  store data.
- wb_sel_o  out  DATA_WIDTH/8  byte lane enables.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i, wb_err_i  in  1 each  cycle termination.

## Operation
- FSM states:
  - IDLE: accept a request.
  - BUS: Wishbone cycle open.
  - RESP: one-cycle completion.
- IDLE:
  - With mem_req_i=1 and the access aligned (address modulo size bytes = 0) and its size legal: register the address, lane, size, unsigned flag and we. Drive cyc=stb=1, we, adr, sel and dat_o from registers. Go to BUS.
  - If the access is misaligned or its size illegal: no bus cycle. Go to RESP with the error flag set.
- Store data: the low size bytes of mem_wdata_i are shifted to lane addr[lsb bits]. wb_sel_o sets the matching contiguous bits (byte at addr 2 gives 4'b0100; half at addr 2 gives 4'b1100). Unselected lanes are 0.
- BUS:
  - On wb_ack_i: capture wb_dat_i, shift the selected lane down, then sign- or zero-extend to DATA_WIDTH.
  - On wb_err_i: set the error flag. wb_err_i takes priority if both it and ack are high.
  - On timeout: set the error flag.
  - In all three cases drop cyc, stb and we on the same edge and go to RESP.
- RESP:
  - mem_done_o=1, and mem_err_o=error flag.
  - mem_rdata_o holds load data. It is 0 for stores and for errors.
  - mem_req_i is ignored. Next state is always IDLE.
- stall_o = (state==IDLE && mem_req_i) || state==BUS. It is 0 in RESP.
- Timeout counter: cleared on entry to BUS, increments each BUS cycle without termination. Abort when the count equals TIMEOUT_CYCLES-1.

## Timing
- Reset values:
  - All outputs 0: cyc, stb, we, adr, dat_o, sel, rdata, done, err.
  - State IDLE, counter 0.
  - stall_o follows mem_req_i.
- Reset mid-transaction drops cyc/stb immediately (asynchronously). No done pulse is produced.
- All Wishbone outputs are registered. With an ack in the first BUS cycle:
  - Edge 0 accepts the request.
  - Cycle 1: cyc/stb high, ack seen.
  - Cycle 2: RESP, done high.
  - Cycle 3: IDLE, where a back-to-back request can be accepted.
  - Total: 3 cycles per access.
- Misaligned access: done/err in the cycle after acceptance; wb_cyc_o never rises.
- Wishbone outputs are stable for the whole time cyc=1. Termination is sampled only when cyc=stb=1.

## Structure
- Package dmem_pkg:
  - mem_size_e (BYTE/HALF/WORD/DWORD).
  - state_e (IDLE/BUS/RESP).
  - Function size_bytes().
  - Function is_aligned().
- Sub-module dmem_lane_align (combinational), computing:
  - The sel mask and the shifted store data.
  - Load lane extraction and extension.
  - It is parametrised by DATA_WIDTH and shared with the future instruction-fetch port.

## Test plan
- Signed byte load at 0x1003, wb_dat_i=0x80112233, ack in 1 cycle:
  - wb_sel_o=4'b1000, wb_adr_o=0x1000.
  - done in cycle 2 with rdata=0xFFFFFF80, err=0.
- Unsigned half load at 0x2002, wb_dat_i=0xBEEF0000 → rdata=0x0000BEEF.
- Half store of 0x1234 at 0x3002 → wb_dat_o=0x12340000, sel=4'b1100, we=1, rdata=0.
- Word load at 0x4001 → no cyc ever, done=err=1 one cycle after the request.
- TIMEOUT_CYCLES=4, no ack:
  - cyc stays high for exactly 4 cycles, then drops.
  - done=err=1.
  - A following request with ack completes normally.
- Other termination and reset cases:
  - wb_err_i and wb_ack_i together → err=1.
  - rst_i pulsed while in BUS → cyc=0 immediately and no done pulse.
  - After reset is released, a new request completes.
